// File: rtl/capture_pkg.sv
// ============================================================================
// capture_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the capture engine slice:
//   capture_state_e  - run-state encoding of the capture engine FSM
//   capture_addr_w() - buffer address width derived from the buffer depth
// ============================================================================
package capture_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DRAIN = 2'd3
    } capture_state_e;

    // Smallest w with 2**w >= depth; depth is expected to be a power of two.
    function automatic int unsigned capture_addr_w(input int unsigned depth);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 31; i++) begin
            if ((32'd1 << i) < depth) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage : capture_pkg

// File: rtl/capture_ram.sv
// ============================================================================
// capture_ram
// ----------------------------------------------------------------------------
// Simple dual-port sample buffer: one write port, one read port with a
// registered (1-cycle) read that holds its value while re_i is low. No reset
// on the array or the read register so the buffer maps onto block RAM.
//
// Ports:
//   clk_i    - clock
//   we_i     - write enable
//   waddr_i  - write address
//   wdata_i  - write data
//   re_i     - read enable; rdata_o updates on the next rising edge
//   raddr_i  - read address
//   rdata_o  - registered read data
// ============================================================================
module capture_ram #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule : capture_ram

// File: rtl/capture_engine.sv
// ============================================================================
// capture_engine
// ----------------------------------------------------------------------------
// Logic-analyser style capture engine. After arm, data_in is sampled into a
// circular buffer once every divider+1 clocks. A trigger (level qualifier plus
// optional per-channel edge detect) ends the pre-trigger phase; delay_count
// further samples are captured, then the newest N = min(read_count, fill)
// samples are streamed out oldest-first on a valid/ready interface.
//
// Optional feature: define CAPTURE_TRIG_ADDR_EN to add output trig_addr
// (buffer address of the triggering sample).
//
// Ports:
//   clock        - sole clock, rising edge
//   reset        - asynchronous, active-low
//   data_in      - probe data (already synchronised)
//   divider      - one sample every divider+1 clocks
//   trig_rising  - per-channel rising-edge trigger enables
//   trig_falling - per-channel falling-edge trigger enables
//   trig_mask    - level qualifier mask
//   trig_value   - level qualifier value
//   read_count   - samples to return
//   delay_count  - post-trigger samples to capture
//   arm, abort   - single-cycle command pulses (abort wins)
//   out_data     - readout sample
//   out_valid    - readout valid
//   out_ready    - readout ready
//   busy         - engine not idle
//   triggered    - trigger seen during the current/last run
//   trig_addr    - (CAPTURE_TRIG_ADDR_EN only) address of triggering sample
// ============================================================================
module capture_engine
    import capture_pkg::*;
#(
    parameter  int unsigned SAMPLE_WIDTH = 8,
    parameter  int unsigned DEPTH        = 1024,
    parameter  int unsigned DIV_WIDTH    = 24,
    localparam int unsigned ADDR_W       = capture_addr_w(DEPTH)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [SAMPLE_WIDTH-1:0] data_in,
    input  logic [DIV_WIDTH-1:0]    divider,
    input  logic [SAMPLE_WIDTH-1:0] trig_rising,
    input  logic [SAMPLE_WIDTH-1:0] trig_falling,
    input  logic [SAMPLE_WIDTH-1:0] trig_mask,
    input  logic [SAMPLE_WIDTH-1:0] trig_value,
    input  logic [ADDR_W:0]         read_count,
    input  logic [ADDR_W:0]         delay_count,
    input  logic                    arm,
    input  logic                    abort,
    output logic [SAMPLE_WIDTH-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    triggered
`ifdef CAPTURE_TRIG_ADDR_EN
    ,
    output logic [ADDR_W-1:0]       trig_addr
`endif
);

    localparam logic [ADDR_W:0] FILL_MAX = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    capture_state_e          state_q;
    logic [ADDR_W-1:0]       wptr_q;
    logic [ADDR_W:0]         fill_q;
    logic [DIV_WIDTH-1:0]    div_q;
    logic [ADDR_W:0]         post_q;
    logic [SAMPLE_WIDTH-1:0] prev_q;
    logic                    have_prev_q;
    logic                    triggered_q;
    logic [ADDR_W-1:0]       rptr_q;
    logic [ADDR_W:0]         rem_q;
    logic                    setup_q;
    logic                    out_valid_q;
`ifdef CAPTURE_TRIG_ADDR_EN
    logic [ADDR_W-1:0]       trig_addr_q;
`endif

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                    capturing;
    logic                    tick;
    logic                    wr_en;
    logic                    level_ok;
    logic                    edge_en;
    logic                    edge_hit;
    logic                    match;
    logic [ADDR_W:0]         n_len;
    logic                    pop;
    logic                    adv;
    logic [SAMPLE_WIDTH-1:0] rd_data;

    assign capturing = (state_q == ARMED) || (state_q == POST);
    assign tick      = (div_q == '0);
    assign wr_en     = capturing && tick;

    assign level_ok  = ((data_in ^ trig_value) & trig_mask) == '0;
    assign edge_en   = |(trig_rising | trig_falling);
    assign edge_hit  = |((~prev_q & data_in & trig_rising) |
                         (prev_q & ~data_in & trig_falling));
    // Edge terms need a previous ticked sample; none exists on the first tick.
    assign match     = level_ok && (!edge_en || (have_prev_q && edge_hit));

    // fill_q saturates at DEPTH, so this min also bounds N by DEPTH.
    assign n_len     = (read_count < fill_q) ? read_count : fill_q;

    assign pop       = out_valid_q && out_ready;
    // A read is issued whenever the output slot is empty or being emptied;
    // the RAM read register is the output stage, so it holds on a stall.
    assign adv       = (state_q == DRAIN) && !setup_q && (rem_q != '0) &&
                       (!out_valid_q || out_ready);

    // ------------------------------------------------------------------
    // Sample buffer
    // ------------------------------------------------------------------
    capture_ram #(
        .WIDTH  (SAMPLE_WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (clock),
        .we_i    (wr_en),
        .waddr_i (wptr_q),
        .wdata_i (data_in),
        .re_i    (adv),
        .raddr_i (rptr_q),
        .rdata_o (rd_data)
    );

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            wptr_q      <= '0;
            fill_q      <= '0;
            div_q       <= '0;
            post_q      <= '0;
            prev_q      <= '0;
            have_prev_q <= 1'b0;
            triggered_q <= 1'b0;
            rptr_q      <= '0;
            rem_q       <= '0;
            setup_q     <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef CAPTURE_TRIG_ADDR_EN
            trig_addr_q <= '0;
`endif
        end else if (abort) begin
            // Covers arm+abort in the same cycle: nothing is started.
            state_q     <= IDLE;
            setup_q     <= 1'b0;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arm) begin
                        state_q     <= ARMED;
                        wptr_q      <= '0;
                        fill_q      <= '0;
                        triggered_q <= 1'b0;
                        have_prev_q <= 1'b0;
                        div_q       <= '0;  // first tick on the next cycle
`ifdef CAPTURE_TRIG_ADDR_EN
                        trig_addr_q <= '0;
`endif
                    end
                end

                ARMED, POST: begin
                    if (tick) begin
                        div_q       <= divider;
                        wptr_q      <= wptr_q + 1'b1;
                        prev_q      <= data_in;
                        have_prev_q <= 1'b1;
                        if (fill_q != FILL_MAX) begin
                            fill_q <= fill_q + 1'b1;
                        end
                        if (state_q == ARMED) begin
                            if (match) begin
                                triggered_q <= 1'b1;
`ifdef CAPTURE_TRIG_ADDR_EN
                                trig_addr_q <= wptr_q;
`endif
                                if (delay_count == '0) begin
                                    state_q <= DRAIN;
                                    setup_q <= 1'b1;
                                end else begin
                                    state_q <= POST;
                                    post_q  <= delay_count;
                                end
                            end
                        end else begin
                            post_q <= post_q - 1'b1;
                            if (post_q == CNT_ONE) begin
                                state_q <= DRAIN;
                                setup_q <= 1'b1;
                            end
                        end
                    end else begin
                        div_q <= div_q - 1'b1;
                    end
                end

                DRAIN: begin
                    if (setup_q) begin
                        // Capture has stopped, so fill_q/wptr_q are final.
                        setup_q <= 1'b0;
                        rem_q   <= n_len;
                        rptr_q  <= wptr_q - n_len[ADDR_W-1:0];
                        if (n_len == '0) begin
                            state_q <= IDLE;
                        end
                    end else if (adv) begin
                        rptr_q      <= rptr_q + 1'b1;
                        rem_q       <= rem_q - 1'b1;
                        out_valid_q <= 1'b1;
                    end else if (pop) begin
                        // Last beat leaving with nothing left to read.
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end else if (!out_valid_q && (rem_q == '0)) begin
                        state_q <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_valid = out_valid_q;
    assign out_data  = out_valid_q ? rd_data : '0;
    assign busy      = (state_q != IDLE);
    assign triggered = triggered_q;
`ifdef CAPTURE_TRIG_ADDR_EN
    assign trig_addr = trig_addr_q;
`endif

endmodule : capture_engine

// File: tb/tb_capture_engine.sv
// ============================================================================
// tb_capture_engine
// ----------------------------------------------------------------------------
// Self-checking bench for capture_engine (DEPTH=16). Each capture run derives
// the expected readout from the stimulus table: ticked samples, first sample
// meeting the trigger rule, delay_count more samples, newest N returned.
// Expected beats are queued; a monitor pops and compares each transfer.
// ============================================================================
module tb_capture_engine;

    localparam int unsigned SW       = 8;
    localparam int unsigned DEPTH    = 16;
    localparam int unsigned DW       = 8;
    localparam int unsigned AW       = 4;
    localparam int unsigned STIM_LEN = 128;
    localparam int unsigned BUDGET   = 800;

    logic          clock = 1'b0;
    logic          reset;
    logic [SW-1:0] data_in;
    logic [DW-1:0] divider;
    logic [SW-1:0] trig_rising, trig_falling, trig_mask, trig_value;
    logic [AW:0]   read_count, delay_count;
    logic          arm, abort;
    logic [SW-1:0] out_data;
    logic          out_valid, out_ready, busy, triggered;
`ifdef CAPTURE_TRIG_ADDR_EN
    logic [AW-1:0] trig_addr;
`endif

    int            errors = 0;
    int            checks = 0;
    int            cyc    = 0;
    logic [SW-1:0] stim [256];
    logic [SW-1:0] exp_q [$];
    int            beats;
    int            first_valid_cyc;
    int            last_beat_cyc;
    int unsigned   rdy_mode = 0;  // 0: ready high, 1: random, 2: ready low
    logic          held = 1'b0;
    logic [SW-1:0] held_data;

    capture_engine #(
        .SAMPLE_WIDTH (SW),
        .DEPTH        (DEPTH),
        .DIV_WIDTH    (DW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .data_in      (data_in),
        .divider      (divider),
        .trig_rising  (trig_rising),
        .trig_falling (trig_falling),
        .trig_mask    (trig_mask),
        .trig_value   (trig_value),
        .read_count   (read_count),
        .delay_count  (delay_count),
        .arm          (arm),
        .abort        (abort),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy),
        .triggered    (triggered)
`ifdef CAPTURE_TRIG_ADDR_EN
        ,
        .trig_addr    (trig_addr)
`endif
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cyc_step();
        @(posedge clock);
        #1;
    endtask

    // Ready driver
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: transfers happen on the next rising edge when valid && ready.
    always @(negedge clock) begin
        if (reset && out_valid) begin
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            if (held) check("hold_data", 32'(out_data), 32'(held_data));
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %0h expected no beat (cycle %0d)", out_data, cyc);
                end else begin
                    check("beat", 32'(out_data), 32'(exp_q.pop_front()));
                end
                beats++;
                last_beat_cyc = cyc;
                held = 1'b0;
            end else begin
                held      = 1'b1;
                held_data = out_data;
            end
        end else begin
            held = 1'b0;
        end
    end

    function automatic int unsigned tcyc(input int unsigned j, input int unsigned div);
        return 1 + j * (div + 1);
    endfunction

    function automatic bit trig_hit(input logic [SW-1:0] s, input logic [SW-1:0] p, input bit has_prev,
                                    input logic [SW-1:0] rise, input logic [SW-1:0] fall,
                                    input logic [SW-1:0] mask, input logic [SW-1:0] val);
        if (((s ^ val) & mask) != '0) return 1'b0;
        if ((rise | fall) == '0) return 1'b1;
        if (!has_prev) return 1'b0;
        return ((~p & s & rise) | (p & ~s & fall)) != '0;
    endfunction

    // One complete capture run driven from stim[]; stim[c] is data_in during
    // cycle c after the arm cycle (cycle 0).
    task automatic run_capture(input int unsigned div, input logic [SW-1:0] rise, input logic [SW-1:0] fall,
                               input logic [SW-1:0] mask, input logic [SW-1:0] val,
                               input int unsigned delay, input int unsigned rcnt, input int unsigned rmode);
        int          k;
        int unsigned total, n, c_last, base, cb;
        bit          done;
        k = -1;
        total = 0; n = 0; c_last = 0; cb = 0;
        for (int unsigned j = 0; tcyc(j, div) < STIM_LEN; j++) begin
            if (trig_hit(stim[tcyc(j, div)], (j > 0) ? stim[tcyc(j - 1, div)] : '0, j > 0,
                         rise, fall, mask, val)) begin
                k = int'(j);
                break;
            end
        end
        exp_q.delete();
        if (k >= 0) begin
            total  = int'(k) + 1 + delay;
            n      = (rcnt < total) ? rcnt : total;
            n      = (n < DEPTH) ? n : DEPTH;
            c_last = tcyc(total - 1, div);
            for (int unsigned i = total - n; i < total; i++) exp_q.push_back(stim[tcyc(i, div)]);
        end
        beats = 0;
        first_valid_cyc = -1;
        last_beat_cyc = -1;
        rdy_mode = rmode;

        cyc_step();
        divider      = DW'(div);
        trig_rising  = rise;
        trig_falling = fall;
        trig_mask    = mask;
        trig_value   = val;
        delay_count  = (AW + 1)'(delay);
        read_count   = (AW + 1)'(rcnt);
        arm          = 1'b1;
        data_in      = stim[0];
        base         = cyc;
        done         = 1'b0;
        for (int unsigned c = 1; c < BUDGET; c++) begin
            cyc_step();
            arm   = 1'b0;
            abort = 1'b0;
            if (!busy) begin
                done = 1'b1;
                cb   = cyc;
                break;
            end
            data_in = (c < 256) ? stim[c] : '0;
            if (k < 0 && c == STIM_LEN) abort = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL run_timeout: busy still high after %0d cycles", BUDGET);
            abort = 1'b1;
            cyc_step();
            abort = 1'b0;
        end
        check("beat_count", 32'(beats), 32'(n));
        check("leftover_expected", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        check("triggered", 32'(triggered), 32'(k >= 0));
        if (k < 0) begin
            check("abort_to_idle", cb - base, STIM_LEN + 1);
        end else begin
`ifdef CAPTURE_TRIG_ADDR_EN
            check("trig_addr", 32'(trig_addr), 32'(k) % DEPTH);
`endif
            if (n > 0) begin
                check("valid_not_early", 32'(first_valid_cyc >= int'(base + c_last + 3)), 32'd1);
                check("idle_after_last_beat", cb, 32'(last_beat_cyc + 1));
                if (rmode == 0) check("back_to_back", 32'(last_beat_cyc - first_valid_cyc), n - 1);
            end
        end
    endtask

    task automatic fill_random();
        foreach (stim[i]) stim[i] = SW'($urandom);
    endtask

    initial begin
        reset = 1'b0;
        data_in = '0; divider = '0;
        trig_rising = '0; trig_falling = '0; trig_mask = '0; trig_value = '0;
        read_count = '0; delay_count = '0;
        arm = 1'b0; abort = 1'b0;

        // Reset state (arm held high must be ignored while in reset)
        arm = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        arm = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_triggered", 32'(triggered), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
`ifdef CAPTURE_TRIG_ADDR_EN
        check("rst_trig_addr", 32'(trig_addr), 32'd0);
`endif
        @(negedge clock);
        reset = 1'b1;
        repeat (2) cyc_step();

        // divider 3, trigger on first tick, 4 post samples, 5 beats
        fill_random();
        run_capture(3, '0, '0, '0, '0, 4, 5, 0);

        // rising edge on bit 0 at tick 20, buffer wraps, 16 beats
        for (int unsigned c = 0; c < 256; c++) stim[c] = (c >= 20) ? 8'h01 : 8'h00;
        run_capture(0, 8'h01, '0, '0, '0, 8, 16, 0);

        // read_count larger than captured samples
        fill_random();
        run_capture(1, '0, '0, '0, '0, 2, 10, 0);

        // random backpressure on a wrapped buffer
        fill_random();
        run_capture(0, '0, '0, '0, '0, 20, 16, 1);

        // falling edge on bit 7 qualified by bit 0 high
        for (int unsigned c = 0; c < 256; c++) stim[c] = (c < 30) ? 8'h81 : ((c % 2 == 0) ? 8'h01 : 8'h00);
        run_capture(1, '0, 8'h80, 8'h01, 8'h01, 5, 31, 1);

        // read_count 0 and delay_count 0
        fill_random();
        run_capture(0, '0, '0, '0, '0, 3, 0, 0);
        fill_random();
        run_capture(2, '0, '0, '0, '0, 0, 4, 0);

        // abort during POST, then arm+abort together
        exp_q.delete();
        beats = 0;
        rdy_mode = 0;
        cyc_step();
        divider = DW'(5); trig_rising = '0; trig_falling = '0; trig_mask = '0;
        delay_count = (AW + 1)'(20); read_count = (AW + 1)'(16);
        arm = 1'b1;
        cyc_step();
        arm = 1'b0;
        repeat (12) cyc_step();
        check("post_busy", 32'(busy), 32'd1);
        check("post_triggered", 32'(triggered), 32'd1);
        abort = 1'b1;
        cyc_step();
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_keeps_triggered", 32'(triggered), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        arm = 1'b1;
        abort = 1'b1;
        cyc_step();
        arm = 1'b0;
        abort = 1'b0;
        check("arm_abort_busy", 32'(busy), 32'd0);
        check("arm_abort_triggered", 32'(triggered), 32'd1);
        repeat (30) cyc_step();
        check("abort_no_beats", 32'(beats), 32'd0);

        // reset during DRAIN with output stalled
        fill_random();
        rdy_mode = 2;
        cyc_step();
        divider = '0; trig_mask = '0; trig_rising = '0; trig_falling = '0;
        delay_count = (AW + 1)'(3); read_count = (AW + 1)'(4);
        arm = 1'b1;
        data_in = stim[0];
        cyc_step();
        arm = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (out_valid) break;
            cyc_step();
        end
        check("drain_reached", 32'(out_valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_triggered", 32'(triggered), 32'd0);
        check("mid_rst_out_data", 32'(out_data), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        rdy_mode = 0;
        exp_q.delete();
        fill_random();
        run_capture(1, '0, '0, '0, '0, 6, 7, 0);

        // randomized runs
        for (int r = 0; r < 20; r++) begin
            logic [SW-1:0] rise, fall;
            fill_random();
            rise = ($urandom_range(0, 2) == 0) ? SW'($urandom & $urandom) : '0;
            fall = ($urandom_range(0, 2) == 0) ? SW'($urandom & $urandom) : '0;
            run_capture($urandom_range(0, 2), rise, fall, SW'($urandom & $urandom & $urandom), SW'($urandom),
                        $urandom_range(0, 20), $urandom_range(0, 31), $urandom_range(0, 1));
        end

        repeat (3) cyc_step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (errors=%0d checks=%0d)", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_capture_engine

// File: doc/capture_engine.md
CAPTURE_ENGINE -- requirements
Module: capture_engine

Interface
REQ-001 SHALL have parameter SAMPLE_WIDTH, default 8: channel count, one bit per probed signal.
REQ-002 SHALL have parameter DEPTH, default 1024: sample buffer entries; power of two, 16..65536.
REQ-003 SHALL have parameter DIV_WIDTH, default 24: sample-rate divider width.
REQ-004 SHALL have port clock  in  1  (sole clock; all logic on its rising edge).
REQ-005 SHALL have port reset  in  1  (asynchronous, active-low).
REQ-006 SHALL have port data_in  in  SAMPLE_WIDTH  (probe data, already synchronised).
REQ-007 SHALL have port divider  in  DIV_WIDTH  (one sample every divider+1 clocks).
REQ-008 SHALL have ports trig_rising and trig_falling  in  SAMPLE_WIDTH  (per-channel edge enables).
REQ-009 SHALL have ports trig_mask and trig_value  in  SAMPLE_WIDTH  (level qualifier).
REQ-010 SHALL have ports read_count and delay_count  in  ADDR_W+1  (samples returned; post-trigger samples), where ADDR_W = log2(DEPTH).
REQ-011 SHALL have ports arm and abort  in  1  (single-cycle command pulses).
REQ-012 SHALL have ports out_data out SAMPLE_WIDTH, out_valid out 1, out_ready in 1  (readout stream).
REQ-013 SHALL have ports busy and triggered  out  1  (busy = state not IDLE; triggered = trigger seen this run).

Function
REQ-014 SHALL implement states IDLE, ARMED, POST, DRAIN.
REQ-015 IDLE->ARMED on arm: clear write pointer, fill count, triggered; load divider counter so the first tick occurs on the cycle after arm.
REQ-016 Tick: divider counter counts down; tick when 0, then reload divider; divider=0 means tick every clock.
REQ-017 In ARMED and POST, each tick SHALL write data_in at the write pointer (wrap modulo DEPTH) and increment fill count, saturating at DEPTH.
REQ-018 Trigger match on a tick SHALL require ((data_in ^ trig_value) & trig_mask)==0 AND, if trig_rising|trig_falling is non-zero, at least one enabled channel with rising (prev 0, cur 1) or falling (prev 1, cur 0) edge versus the previous ticked sample.
REQ-019 On the first tick after arm there is no previous sample; edge terms SHALL be false; all-zero masks SHALL trigger on that first tick.
REQ-020 ARMED->POST on match: set triggered, load post counter with delay_count; the triggering sample is written and counts as pre-trigger.
REQ-021 POST SHALL decrement on each tick after writing; ->DRAIN when the write completing count 0 occurs; delay_count=0 goes ARMED->DRAIN directly.
REQ-022 Effective read length N = min(read_count, fill count, DEPTH); DRAIN SHALL emit N samples oldest-first, starting at write pointer minus N modulo DEPTH.
REQ-023 out_valid SHALL rise no earlier than 2 cycles after entering DRAIN; a beat transfers when out_valid && out_ready; out_data SHALL hold while out_valid && !out_ready.
REQ-024 DRAIN->IDLE the cycle after the last beat transfers; N=0 SHALL go to IDLE with no beat.
REQ-025 Back-to-back beats SHALL sustain one per clock while out_ready is held high.
REQ-026 abort SHALL force IDLE on the next edge from any state, deassert out_valid, and keep triggered.
REQ-027 arm outside IDLE SHALL be ignored; arm and abort in the same cycle: abort wins.
REQ-028 Configuration inputs SHALL be read live; changes mid-run are the user's responsibility.

Reset
REQ-029 On reset low: state IDLE; out_valid, busy, triggered, out_data, all pointers and counters 0; buffer contents undefined.
REQ-030 Reset deassertion SHALL be synchronised by the instantiating top; no arm honoured while reset is low.

Configuration
REQ-031 Macro CAPTURE_TRIG_ADDR_EN defined: SHALL add output trig_addr ADDR_W, the write address of the triggering sample, latched on match, 0 on reset/arm.
REQ-032 Without CAPTURE_TRIG_ADDR_EN: trig_addr port and its register SHALL be absent; all other behaviour identical.

Structure
REQ-033 Package capture_pkg SHALL hold the state enum type and the ADDR_W derivation function.
REQ-034 Buffer SHALL be sub-module capture_ram: simple dual-port, one write port, one read port, 1-cycle registered read, inferable as block RAM.

Verification
REQ-035 divider=3, masks 0, delay_count=4, read_count=5: trigger on first tick; 5 samples written 4 clocks apart; 5 beats, oldest first.
REQ-036 trig_rising=0x01, input 0x00 then 0x01 at tick 20, DEPTH=16, delay_count=8, read_count=16: buffer wraps; 16 beats ending with the 8th post-trigger sample; trig_addr=19 mod 16=3 with macro.
REQ-037 read_count=10 with only 3 samples captured: exactly 3 beats, then IDLE.
REQ-038 out_ready toggled pseudo-randomly during DRAIN: no lost, duplicated or changed beats.
REQ-039 abort during POST, then arm and abort same cycle: IDLE after each, busy=0, no beat emitted.
REQ-040 reset asserted mid-DRAIN: out_valid and busy drop immediately; next arm runs normally.
